port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/rv32i_types.sv | 30 +++
 rtl/req_capture.sv | 31 +++
 rtl/port_arbiter.sv | 130 +++++++++++++
 tb/tb_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the memory-port arbiter: FSM state encoding, bus widths,
// the captured-request payload and an address helper.
package rv32i_types;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_A = 3'd1,
    SERVE_B = 3'd2,
    RESP_A  = 3'd3,
    RESP_B  = 3'd4
  } arbiter_state_t;

  // Request latched at the grant edge; drives the downstream port.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic              write;
  } req_t;

  // Downstream memory is word addressed: clear the byte offset.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/req_capture.sv
// Request capture register: holds address/wdata/wmask/op for the granted
// transaction so downstream signals stay stable until the next grant.
// Ports: clk, rst_n (async, active-low), load_i (grant strobe),
//        req_i (request to latch), req_o (latched request).
module req_capture
  import rv32i_types::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  req_t req_i,
  output req_t req_o
);

  req_t req_q;
  req_t req_d;

  // Load on grant, otherwise hold.
  always_comb begin
    req_d = req_q;
    if (load_i) req_d = req_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= '0;
    else        req_q <= req_d;
  end

  assign req_o = req_q;

endmodule

// File: rtl/port_arbiter.sv
// Two-port arbiter sharing one downstream memory between an instruction
// read port (a) and a data read/write port (b). One transaction at a time.
// Ports: clk, rst_n (async, active-low);
//        port a: read_a, address_a -> rdata_a, resp_a;
//        port b: read_b, write_b, wmask_b, address_b, wdata_b -> rdata_b, resp_b;
//        memory: pmem_read/write/address/wdata/wmask -> pmem_rdata, pmem_resp.
module port_arbiter
  import rv32i_types::*;
#(
  parameter bit B_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_a,
  input  logic [ADDR_W-1:0] address_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              resp_a,
  input  logic              read_b,
  input  logic              write_b,
  input  logic [MASK_W-1:0] wmask_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              resp_b,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [MASK_W-1:0] pmem_wmask,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arbiter_state_t state_q;
  req_t           req_d;
  req_t           req_q;
  logic           req_b_c;
  logic           grant_a_c;
  logic           grant_b_c;

  // Grants only happen in IDLE; read+write on port b counts as one request.
  assign req_b_c   = read_b | write_b;
  assign grant_b_c = (state_q == IDLE) && req_b_c && (B_PRIORITY || !read_a);
  assign grant_a_c = (state_q == IDLE) && read_a && !grant_b_c;

  // Select the payload of the winning port (write wins over read on b).
  always_comb begin
    req_d = '0;
    if (grant_b_c) begin
      req_d.addr  = address_b;
      req_d.wdata = wdata_b;
      req_d.wmask = wmask_b;
      req_d.write = write_b;
    end else begin
      req_d.addr  = address_a;
    end
  end

  req_capture u_req_capture (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (grant_a_c | grant_b_c),
    .req_i  (req_d),
    .req_o  (req_q)
  );

  assign pmem_address = word_align(req_q.addr);
  assign pmem_wdata   = req_q.wdata;
  assign pmem_wmask   = req_q.wmask;

  // Arbitration FSM with registered strobes, responses and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      resp_a     <= 1'b0;
      resp_b     <= 1'b0;
      rdata_a    <= '0;
      rdata_b    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_b_c) begin
            state_q    <= SERVE_B;
            pmem_read  <= !write_b;
            pmem_write <= write_b;
          end else if (grant_a_c) begin
            state_q    <= SERVE_A;
            pmem_read  <= 1'b1;
          end
        end
        SERVE_A: begin
          if (pmem_resp) begin
            state_q   <= RESP_A;
            pmem_read <= 1'b0;
            resp_a    <= 1'b1;
            rdata_a   <= pmem_rdata;
          end
        end
        SERVE_B: begin
          if (pmem_resp) begin
            state_q    <= RESP_B;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            resp_b     <= 1'b1;
            // A write completion carries no data; keep the last read value.
            if (!req_q.write) rdata_b <= pmem_rdata;
          end
        end
        RESP_A: begin
          state_q <= IDLE;
          resp_a  <= 1'b0;
        end
        RESP_B: begin
          state_q <= IDLE;
          resp_b  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          resp_a     <= 1'b0;
          resp_b     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter with a response scoreboard: stimulus pushes
// expected rdata per port, a negedge monitor pops on every resp pulse.
module tb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_a;
  logic [31:0] address_a;
  logic [31:0] rdata_a;
  logic        resp_a;
  logic        read_b;
  logic        write_b;
  logic [3:0]  wmask_b;
  logic [31:0] address_b;
  logic [31:0] wdata_b;
  logic [31:0] rdata_b;
  logic        resp_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  port_arbiter #(.B_PRIORITY(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_a       (read_a),
    .address_a    (address_a),
    .rdata_a      (rdata_a),
    .resp_a       (resp_a),
    .read_b       (read_b),
    .write_b      (write_b),
    .wmask_b      (wmask_b),
    .address_b    (address_b),
    .wdata_b      (wdata_b),
    .rdata_b      (rdata_b),
    .resp_b       (resp_b),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle downstream completion in the current cycle.
  task automatic respond(input logic [31:0] data);
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    step();
    pmem_resp  = 1'b0;
    pmem_rdata = 32'h0;
  endtask

  // Scoreboard monitor: every resp pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (resp_a === 1'b1) begin
        if (exp_a_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp_a: got rdata_a 0x%08h expected no response", rdata_a);
        end else begin
          check("rdata_a_on_resp", rdata_a, exp_a_q.pop_front());
        end
      end
      if (resp_b === 1'b1) begin
        if (exp_b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp_b: got rdata_b 0x%08h expected no response", rdata_b);
        end else begin
          check("rdata_b_on_resp", rdata_b, exp_b_q.pop_front());
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; read_a = 0; address_a = 0; read_b = 0; write_b = 0;
    wmask_b = 0; address_b = 0; wdata_b = 0; pmem_rdata = 0; pmem_resp = 0;
    step(); step();
    // Reset values
    check("rst_pmem_read",  32'(pmem_read), 32'h0);
    check("rst_pmem_write", 32'(pmem_write), 32'h0);
    check("rst_resp",       32'({resp_a, resp_b}), 32'h0);
    check("rst_rdata_a",    rdata_a, 32'h0);
    check("rst_rdata_b",    rdata_b, 32'h0);
    check("rst_pmem_addr",  pmem_address, 32'h0);
    check("rst_pmem_wdata", pmem_wdata, 32'h0);
    check("rst_pmem_wmask", 32'(pmem_wmask), 32'h0);
    rst_n = 1'b1;
    step();

    // Single instruction read, unaligned address, response after 3 cycles
    read_a = 1; address_a = 32'h0000_0106;
    step();
    check("t1_c1_read",  32'(pmem_read), 32'h1);
    check("t1_c1_write", 32'(pmem_write), 32'h0);
    check("t1_c1_addr",  pmem_address, 32'h0000_0104);
    step();
    check("t1_c2_addr",  pmem_address, 32'h0000_0104);
    step();
    check("t1_c3_addr",  pmem_address, 32'h0000_0104);
    check("t1_c3_noresp", 32'(resp_a), 32'h0);
    exp_a_q.push_back(32'h0050_0093);
    respond(32'h0050_0093);
    check("t1_c4_resp_a", 32'(resp_a), 32'h1);
    check("t1_c4_read",  32'(pmem_read), 32'h0);
    read_a = 0;
    step();
    check("t1_c5_resp_a", 32'(resp_a), 32'h0);
    check("t1_hold_a",   rdata_a, 32'h0050_0093);

    // Simultaneous requests: b first, a granted two cycles after b's pmem_resp
    read_a = 1; address_a = 32'h0000_0200;
    read_b = 1; address_b = 32'h0000_0300;
    step();
    check("t2_b_first_addr", pmem_address, 32'h0000_0300);
    check("t2_b_read", 32'(pmem_read), 32'h1);
    exp_b_q.push_back(32'h1111_1111);
    respond(32'h1111_1111);
    check("t2_resp_b", 32'(resp_b), 32'h1);
    check("t2_rdata_a_kept", rdata_a, 32'h0050_0093);
    read_b = 0;
    step();
    check("t2_idle_noread", 32'(pmem_read), 32'h0);
    step();
    check("t2_a_granted", 32'(pmem_read), 32'h1);
    check("t2_a_addr", pmem_address, 32'h0000_0200);
    exp_a_q.push_back(32'h2222_2222);
    respond(32'h2222_2222);
    check("t2_rdata_b_kept", rdata_b, 32'h1111_1111);
    read_a = 0;
    step();

    // Data write: strobes and payload; rdata_b unchanged despite pmem_rdata
    write_b = 1; address_b = 32'h0000_0080; wdata_b = 32'hDEAD_BEEF; wmask_b = 4'b1100;
    step();
    check("t3_write", 32'(pmem_write), 32'h1);
    check("t3_read",  32'(pmem_read), 32'h0);
    check("t3_addr",  pmem_address, 32'h0000_0080);
    check("t3_wdata", pmem_wdata, 32'hDEAD_BEEF);
    check("t3_wmask", 32'(pmem_wmask), 32'hC);
    exp_b_q.push_back(32'h1111_1111);
    respond(32'hBADB_AD00);
    check("t3_write_off", 32'(pmem_write), 32'h0);
    write_b = 0;
    step();

    // Spurious pmem_resp while idle
    respond(32'hFFFF_FFFF);
    check("t4_no_read",  32'(pmem_read), 32'h0);
    check("t4_no_write", 32'(pmem_write), 32'h0);
    step();
    check("t4_rdata_a", rdata_a, 32'h2222_2222);
    check("t4_rdata_b", rdata_b, 32'h1111_1111);

    // read_b+write_b acts as write; address change mid-transaction ignored
    read_b = 1; write_b = 1; address_b = 32'h0000_0044; wdata_b = 32'h1234_5678; wmask_b = 4'b0000;
    step();
    check("t5_write", 32'(pmem_write), 32'h1);
    check("t5_read",  32'(pmem_read), 32'h0);
    check("t5_wmask", 32'(pmem_wmask), 32'h0);
    address_b = 32'h0000_0999; wdata_b = 32'h0;
    step();
    check("t5_addr_stable",  pmem_address, 32'h0000_0044);
    check("t5_wdata_stable", pmem_wdata, 32'h1234_5678);
    exp_b_q.push_back(32'h1111_1111);
    respond(32'h5555_5555);
    read_b = 0; write_b = 0;
    step();

    // Reset during SERVE_B, then a late pmem_resp
    read_b = 1; address_b = 32'h0000_0010;
    step();
    check("t6_serving", 32'(pmem_read), 32'h1);
    read_b = 0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_read",  32'(pmem_read), 32'h0);
    check("t6_rst_write", 32'(pmem_write), 32'h0);
    check("t6_rst_rdata_b", rdata_b, 32'h0);
    step();
    rst_n = 1'b1;
    respond(32'h0000_CAFE);
    step(); step();
    check("t6_no_read",  32'(pmem_read), 32'h0);
    check("t6_rdata_b",  rdata_b, 32'h0);

    check("pending_a", 32'(exp_a_q.size()), 32'h0);
    check("pending_b", 32'(exp_b_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
